// File: rtl/regfile_read_port.sv
// Register file with a handshaked dual read port: requests are accepted into a
// one-entry output buffer, with write-to-read bypass and a hardwired-zero r0.
module regfile_read_port #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrenable,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [WIDTH-1:0]  writedata,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] readaddr1,
    input  logic [ADDR_W-1:0] readaddr2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  readdata1,
    output logic [WIDTH-1:0]  readdata2
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_readData1;
    logic [WIDTH-1:0] r_readData2;

    logic             w_accept;
    logic             w_writeEn;
    logic [WIDTH-1:0] w_readData1;
    logic [WIDTH-1:0] w_readData2;

    // Writes to r0 are dropped here so the array entry itself stays zero.
    assign w_writeEn = wrenable && (writeaddr != '0);

    assign req_ready  = (r_state == EMPTY) || resp_ready;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (r_state == FULL);
    assign readdata1  = r_readData1;
    assign readdata2  = r_readData2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_writeEn) begin
            r_regs[writeaddr] <= writedata;
        end
    end

    // Both ports share the same selection rule, so equal indices give equal data.
    always_comb begin
        w_readData1 = r_regs[readaddr1];
        if (readaddr1 == '0) begin
            w_readData1 = '0;
        end else if (w_writeEn && (writeaddr == readaddr1)) begin
            w_readData1 = writedata;
        end
    end

    always_comb begin
        w_readData2 = r_regs[readaddr2];
        if (readaddr2 == '0) begin
            w_readData2 = '0;
        end else if (w_writeEn && (writeaddr == readaddr2)) begin
            w_readData2 = writedata;
        end
    end

    // Output data only loads on accept, so a stalled response is immune to writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_readData1 <= '0;
            r_readData2 <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= FULL;
                        r_readData1 <= w_readData1;
                        r_readData2 <= w_readData2;
                    end
                end
                FULL: begin
                    if (w_accept) begin
                        r_readData1 <= w_readData1;
                        r_readData2 <= w_readData2;
                    end else if (resp_ready) begin
                        r_state <= EMPTY;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/regfile_read_port.md
REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 Parameter: WIDTH, default 32, data bits per register.
REQ-002 Parameter: ADDR_W, default 5, register address bits (2^ADDR_W registers, 32 at default).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock, all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wrenable  input  1  write strobe for the storage array.
REQ-007 writeaddr  input  ADDR_W  write register index.
REQ-008 writedata  input  WIDTH  write data.
REQ-009 req_valid  input  1  read request present.
REQ-010 req_ready  output  1  block can accept a read request this cycle.
REQ-011 readaddr1  input  ADDR_W  port-1 read index, sampled on accept.
REQ-012 readaddr2  input  ADDR_W  port-2 read index, sampled on accept.
REQ-013 resp_valid  output  1  readdata1/readdata2 hold a valid response.
REQ-014 resp_ready  input  1  consumer takes the response this cycle.
REQ-015 readdata1  output  WIDTH  registered port-1 result.
REQ-016 readdata2  output  WIDTH  registered port-2 result.

Function
REQ-017 Storage SHALL be 2^ADDR_W registers of WIDTH bits, written on posedge when wrenable=1.
REQ-018 Register 0 SHALL be hardwired zero: writes to index 0 are discarded, and reads of index 0 return 0.
REQ-019 Accept condition SHALL be req_valid && req_ready at a posedge.
REQ-020 req_ready SHALL equal !resp_valid || resp_ready (combinational; one-entry output buffer).
REQ-021 On accept, readdata1/2 SHALL load at that edge, with resp_valid=1 from the next cycle (latency 1).
REQ-022 Bypass: if wrenable=1 and writeaddr equals a nonzero read index at the accept edge, that port SHALL return writedata, not the old contents.
REQ-023 Both ports addressing the same index SHALL return identical data, including under bypass.
REQ-024 States SHALL be EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-025 EMPTY -> FULL on accept; otherwise EMPTY holds.
REQ-026 FULL -> EMPTY when resp_ready=1 and there is no accept.
REQ-027 FULL -> FULL with new data when resp_ready=1 and there is an accept (back-to-back, one response per cycle).
REQ-028 FULL holds when resp_ready=0.
REQ-029 While FULL and resp_ready=0, readdata1/2 SHALL stay stable even if a write changes the addressed register.
REQ-030 Writes SHALL proceed every cycle regardless of handshake state.
REQ-031 A read request SHALL never be dropped or duplicated.

Reset
REQ-032 When reset=1 at posedge: resp_valid=0, readdata1=0, readdata2=0, and all storage registers =0.
REQ-033 Reset SHALL have priority over a simultaneous write or accept; both are discarded.
REQ-034 Reset mid-operation SHALL discard any pending response; req_ready=1 in the cycle after reset deasserts.

Verification
REQ-035 Write 0xDEADBEEF to r5, then request addr1=5, addr2=0 with resp_ready=1 -> next cycle resp_valid=1, readdata1=0xDEADBEEF, readdata2=0.
REQ-036 Write 0x12345678 to r0, then read r0 on both ports -> readdata1=readdata2=0.
REQ-037 In the same cycle, write 0xA5A5A5A5 to r7 and accept a request with addr1=addr2=7 -> both ports return 0xA5A5A5A5.
REQ-038 Hold resp_ready=0 for 3 cycles after a response, with req_valid=1 and a write to the addressed register -> req_ready=0, data stable; on resp_ready=1 the queued request is accepted and returns new data the next cycle.
REQ-039 Stream 4 back-to-back requests (r1..r4) with resp_ready=1 -> resp_valid stays high for 4 consecutive cycles, in-order data.
REQ-040 Assert reset while FULL after writing r3=0xFF -> resp_valid=0, outputs 0, and a subsequent read of r3 returns 0.
